// File: rtl/mm_job_scheduler_if.sv
// Signal bundle around mm_job_scheduler: requester handshake, completion,
// status, the attached matrix multiplier and the shared BRAM port.
interface mm_job_scheduler_if #(
    parameter int L_RAM_SIZE = 3,
    parameter int BITWIDTH   = 32,
    parameter int ADDR_W     = 12
);
    localparam int LA_W = 2 * L_RAM_SIZE + 1;

    logic [1:0]          req_valid;
    logic [2*ADDR_W-1:0] req_base;
    logic [1:0]          req_ready;
    logic [1:0]          cpl_valid;
    logic                cpl_err;
    logic                busy;
    logic [15:0]         jobs_done;

    logic                mm_start;
    logic                mm_reset;
    logic                mm_done;
    logic [LA_W-1:0]     mm_rdaddr;
    logic [LA_W-1:0]     mm_wraddr;
    logic                mm_we;
    logic [BITWIDTH-1:0] mm_wrdata;
    logic [BITWIDTH-1:0] mm_rddata;

    logic [ADDR_W-1:0]   bram_addr;
    logic                bram_we;
    logic [BITWIDTH-1:0] bram_wdata;
    logic [BITWIDTH-1:0] bram_rdata;

    // Scheduler side.
    modport slave (
        input  req_valid, req_base, mm_done, mm_rdaddr, mm_wraddr, mm_we,
               mm_wrdata, bram_rdata,
        output req_ready, cpl_valid, cpl_err, busy, jobs_done, mm_start,
               mm_reset, mm_rddata, bram_addr, bram_we, bram_wdata
    );

    // Environment side: requesters, multiplier and BRAM.
    modport master (
        output req_valid, req_base, mm_done, mm_rdaddr, mm_wraddr, mm_we,
               mm_wrdata, bram_rdata,
        input  req_ready, cpl_valid, cpl_err, busy, jobs_done, mm_start,
               mm_reset, mm_rddata, bram_addr, bram_we, bram_wdata
    );
endinterface

// File: rtl/mm_job_scheduler.sv
// Two-requester round-robin job scheduler for a matrix multiplier sharing a BRAM:
// grants a job, relocates the multiplier's local addresses by the job base, aborts on timeout.
module mm_job_scheduler #(
    parameter int L_RAM_SIZE = 3,
    parameter int BITWIDTH   = 32,
    parameter int ADDR_W     = 12,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              reset,
    mm_job_scheduler_if.slave bus
);
    localparam int          LA_W    = 2 * L_RAM_SIZE + 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_CPL,
        S_ABORT
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       jobs_done_q, jobs_done_d;
    logic              err_q, err_d;
    logic              abort_ph_q, abort_ph_d;

    logic              grant_en;
    logic              grant_idx;
    logic [1:0]        req_ready;
    logic [1:0]        cpl_valid;
    logic              cpl_err;
    logic              mm_start;
    logic              abort_rst;
    logic              in_run;
    logic [LA_W-1:0]   local_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            base_q       <= '0;
            cnt_q        <= '0;
            jobs_done_q  <= '0;
            err_q        <= 1'b0;
            abort_ph_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            jobs_done_q  <= jobs_done_d;
            err_q        <= err_d;
            abort_ph_q   <= abort_ph_d;
        end
    end

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_idx = bus.req_valid[1];
        if (bus.req_valid == 2'b11) begin
            grant_idx = ~last_grant_q;
        end
    end

    // mm_done still high means the previous job's done pulse has not ended yet.
    assign grant_en = (state_q == S_IDLE) && !bus.mm_done && (|bus.req_valid) && !reset;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        jobs_done_d  = jobs_done_q;
        err_d        = err_q;
        abort_ph_d   = abort_ph_q;
        req_ready    = 2'b00;
        cpl_valid    = 2'b00;
        cpl_err      = 1'b0;
        mm_start     = 1'b0;
        abort_rst    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    req_ready[grant_idx] = 1'b1;
                    last_grant_d         = grant_idx;
                    base_d               = grant_idx ? bus.req_base[2*ADDR_W-1:ADDR_W]
                                                     : bus.req_base[ADDR_W-1:0];
                    state_d              = S_START;
                end
            end
            S_START: begin
                mm_start = 1'b1;
                cnt_d    = '0;
                err_d    = 1'b0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + 16'd1;
                if (bus.mm_done) begin
                    state_d = S_CPL;
                end else if (cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    abort_ph_d = 1'b0;
                    state_d    = S_ABORT;
                end
            end
            S_ABORT: begin
                abort_rst  = 1'b1;
                abort_ph_d = 1'b1;
                if (abort_ph_q) begin
                    state_d = S_CPL;
                end
            end
            S_CPL: begin
                cpl_valid[last_grant_q] = 1'b1;
                cpl_err                 = err_q;
                if (!err_q) begin
                    jobs_done_d = jobs_done_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // BRAM relocation is purely combinational so the multiplier sees no extra latency.
    assign in_run     = (state_q == S_RUN);
    assign local_addr = bus.mm_we ? bus.mm_wraddr : bus.mm_rdaddr;

    assign bus.bram_addr  = in_run ? (base_q + ADDR_W'(local_addr)) : '0;
    assign bus.bram_we    = in_run && bus.mm_we;
    assign bus.bram_wdata = in_run ? bus.mm_wrdata : {BITWIDTH{1'b0}};
    assign bus.mm_rddata  = in_run ? bus.bram_rdata : {BITWIDTH{1'b0}};

    assign bus.req_ready = req_ready;
    assign bus.cpl_valid = cpl_valid;
    assign bus.cpl_err   = cpl_err;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.jobs_done = jobs_done_q;
    assign bus.mm_start  = mm_start;
    assign bus.mm_reset  = reset || abort_rst;
endmodule
